cla_nibble_sequencer: RTL and testbench



---
 rtl/cla_nibble_sequencer.sv | 156 +++++++++++++++
 tb/tb_cla_nibble_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder: issues one nibble per cycle through a single
// 4-bit carry-lookahead slice, LSB nibble first, and returns the assembled
// sum, carry-out and signed overflow over a valid/ready result port.

// 4-bit carry-lookahead slice: generate/propagate with fully expanded carries.
module block (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];
endmodule

module cla_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = $clog2(NIB);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("cla_nibble_sequencer: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;

    logic               accept;
    logic               last;
    logic [IDX_W+1:0]   base;
    logic [3:0]         slice_a;
    logic [3:0]         slice_b;
    logic [3:0]         slice_sum;
    logic               slice_cout;

    // in_ready is held low while reset is asserted so nothing is accepted then.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (state_q == ADD) && (idx_q == IDX_W'(NIB - 1));

    // Nibble base offset: the index register drives the operand mux directly.
    assign base    = {idx_q, 2'b00};
    assign slice_a = a_q[base +: 4];
    assign slice_b = b_q[base +: 4];

    block u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking (<=) so every register
        // samples pre-edge values, independent of block ordering.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = ADD;
            ADD:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Operand staging, loaded only on the accept edge.
    always_ff @(posedge clk) begin
        // NOTE: operand registers carry no reset; they are always written at accept
        // before they are read, so a reset would only add fan-out on rst_n.
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // Carry chain, nibble index and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            idx_q   <= '0;
            carry_q <= cin;
            sum_q   <= '0;
        end else if (state_q == ADD) begin
            sum_q[base +: 4] <= slice_sum;
            carry_q          <= slice_cout;
            idx_q            <= idx_q + 1'b1;
            if (last) begin
                cout_q <= slice_cout;
                ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[3] != a_q[WIDTH-1]);
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Directed bench for cla_nibble_sequencer at WIDTH=16: reset values, latency,
// carry chain, overflow, back-pressure, mid-operation reset, and a short
// randomized run checked against plain integer addition.
module tb_cla_nibble_sequencer;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cla_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Hard stop in case the sequence itself stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    // One full transaction: accept, latency, result, output handshake.
    task automatic run_txn(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                           input logic tc, input logic [15:0] es, input logic ec, input logic eo);
        wait_ready(tag);
        in_valid = 1'b1;
        a = ta;
        b = tb_v;
        cin = tc;
        tick();
        in_valid = 1'b0;
        a = 16'hDEAD;
        b = 16'hBEEF;
        cin = ~tc;
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        check({tag, "_ov_e0"}, 32'(out_valid), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("%s_ov_e%0d", tag, k), 32'(out_valid), (k == 4) ? 32'd1 : 32'd0);
        end
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_ov_clr"}, 32'(out_valid), 32'd0);
        check({tag, "_rdy_after"}, 32'(in_ready), 32'd1);
        check({tag, "_sum_hold"}, 32'(sum), 32'(es));
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] full;
        logic        reo;

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        a         = 16'h1111;
        b         = 16'h2222;
        cin       = 1'b1;

        // Reset: in_ready low while held, registered outputs cleared.
        tick();
        tick();
        check("rst_in_ready_low", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready_high", 32'(in_ready), 32'd1);

        // Main function, carry chain and overflow corners.
        run_txn("basic",    16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_txn("carry_b1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_txn("carry_ci", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_txn("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_txn("ovf_neg",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Reset during ADD at index 2 aborts the operation.
        wait_ready("midrst");
        in_valid = 1'b1;
        a = 16'h1234;
        b = 16'h1111;
        cin = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("midrst_no_valid_%0d", k), 32'(out_valid), 32'd0);
        end
        run_txn("after_rst", 16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Back-pressure: result held for 6 cycles while new operands wait.
        wait_ready("bp");
        in_valid = 1'b1;
        a = 16'h0F0F;
        b = 16'h00F1;
        cin = 1'b0;
        tick();
        a = 16'h1111;
        b = 16'h2222;
        cin = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("bp_first_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("bp_hold_valid_%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold_rdy_%0d", k), 32'(in_ready), 32'd0);
            check($sformatf("bp_hold_sum_%0d", k), 32'(sum), 32'h1000);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle_rdy", 32'(in_ready), 32'd1);
        check("bp_idle_sum", 32'(sum), 32'h1000);
        tick();
        in_valid = 1'b0;
        check("bp_second_busy", 32'(in_ready), 32'd0);
        for (int k = 0; k < 3; k++) tick();
        check("bp_second_not_yet", 32'(out_valid), 32'd0);
        tick();
        check("bp_second_valid", 32'(out_valid), 32'd1);
        check("bp_second_sum", 32'(sum), 32'h3334);
        check("bp_second_cout", 32'(cout), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Short randomized run against integer addition.
        for (int n = 0; n < 20; n++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom);
            full = {1'b0, ra} + {1'b0, rb} + 17'(rc);
            reo  = (ra[15] == rb[15]) && (full[15] != ra[15]);
            run_txn($sformatf("rnd%0d", n), ra, rb, rc, full[15:0], full[16], reo);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
